// File: rtl/accumulator_bank.sv
// Accumulator bank: collects partial-sum rows from the systolic array over one
// or more K-tile passes, then drains the finished DEPTH x COLS tile over a
// valid/ready stream.
//
// Handshake semantics (both ports): a beat transfers on a rising clk edge where
// valid and ready are both high. in_ready depends only on the FSM state, and
// out_valid/out_data stay stable until the beat is taken. Neither side gates a
// beat on its data value, so zero rows count like any other row.
module accumulator_bank #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4,
    parameter int COLS     = 2,
    parameter int SATURATE = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     acc_mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_last,
    input  logic [COLS*DATA_W-1:0]   in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [COLS*DATA_W-1:0]   out_data,
    output logic                     out_last,
    output logic                     draining
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                   state_q;
    state_t                   state_d;
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic                     first_pass;
    logic [COLS*DATA_W-1:0]   mem [DEPTH];
    logic [COLS*DATA_W-1:0]   row_next;
    logic                     accept;
    logic                     drain_hs;
    logic                     fill_done;
    logic                     drain_done;

    // Add one lane; with SATURATE set, a same-sign overflow clamps to the
    // signed extreme in the direction of the operands.
    function automatic logic [DATA_W-1:0] lane_add(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] s;
        s = a + b;
        if ((SATURATE != 0) && (a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1])) begin
            lane_add = a[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            lane_add = s;
        end
    endfunction

    // clear drops any beat in its cycle, so it masks both handshakes.
    assign accept     = in_valid  && (state_q == FILL)  && !clear;
    assign drain_hs   = out_ready && (state_q == DRAIN) && !clear;
    assign fill_done  = accept   && in_last && (wr_ptr == LAST_PTR);
    assign drain_done = drain_hs && (rd_ptr == LAST_PTR);

    assign out_data = mem[rd_ptr];
    assign out_last = (state_q == DRAIN) && (rd_ptr == LAST_PTR);
    assign draining = (state_q == DRAIN);

    // Row to store on an accepted beat: overwrite on the first pass or in
    // overwrite mode, otherwise per-lane accumulate onto the stored row.
    always_comb begin
        row_next = in_data;
        if (!first_pass && acc_mode) begin
            for (int c = 0; c < COLS; c++) begin
                row_next[c*DATA_W +: DATA_W] = lane_add(mem[wr_ptr][c*DATA_W +: DATA_W],
                                                        in_data[c*DATA_W +: DATA_W]);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and handshake outputs; clear always returns to FILL.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            FILL: begin
                in_ready = 1'b1;
                if (fill_done) state_d = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (drain_done) state_d = FILL;
            end
            default: state_d = FILL;
        endcase
        if (clear) state_d = FILL;
    end

    // Pointers and the first-pass flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            first_pass <= 1'b1;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            first_pass <= 1'b1;
        end else begin
            if (accept) begin
                if (wr_ptr == LAST_PTR) begin
                    wr_ptr     <= '0;
                    first_pass <= 1'b0;
                end else begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
            end
            if (drain_hs) begin
                if (rd_ptr == LAST_PTR) begin
                    rd_ptr     <= '0;
                    first_pass <= 1'b1;
                end else begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
            end
        end
    end

    // Row storage; only an accepted input beat writes it, drains leave it intact.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem[r] <= '0;
            end
        end else if (accept) begin
            mem[wr_ptr] <= row_next;
        end
    end

endmodule

// File: tb/tb_accumulator_bank.sv
// Bench for accumulator_bank: a wrapping and a saturating instance share every
// input; a tile-level model predicts each drained row from the pass data.
module tb_accumulator_bank;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int COLS  = 2;
    localparam int RW    = COLS * DW;
    localparam longint SMAX = (longint'(1) << (DW - 1)) - 1;
    localparam longint SMIN = -(longint'(1) << (DW - 1));

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;
    logic clear, acc_mode, in_valid, in_last, out_ready;
    logic [RW-1:0] in_data;
    logic in_ready_w, out_valid_w, out_last_w, draining_w;
    logic in_ready_s, out_valid_s, out_last_s, draining_s;
    logic [RW-1:0] out_data_w, out_data_s;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    accumulator_bank #(.DATA_W(DW), .DEPTH(DEPTH), .COLS(COLS), .SATURATE(0)) dut_w (
        .clk(clk), .reset(reset), .clear(clear), .acc_mode(acc_mode),
        .in_valid(in_valid), .in_ready(in_ready_w), .in_last(in_last), .in_data(in_data),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w),
        .out_last(out_last_w), .draining(draining_w)
    );

    accumulator_bank #(.DATA_W(DW), .DEPTH(DEPTH), .COLS(COLS), .SATURATE(1)) dut_s (
        .clk(clk), .reset(reset), .clear(clear), .acc_mode(acc_mode),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_last(in_last), .in_data(in_data),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .out_last(out_last_s), .draining(draining_s)
    );

    // ---------------- scoreboard ----------------
    int n_vec  = 0;
    int n_miss = 0;
    logic [DW-1:0] pd [DEPTH][COLS];     // pass data for the next pass
    logic [DW-1:0] m_wrap [DEPTH][COLS]; // expected tile, wrapping adds
    logic [DW-1:0] m_sat [DEPTH][COLS];  // expected tile, saturating adds
    logic [RW-1:0] exp_q_w[$];
    logic [RW-1:0] exp_q_s[$];

    task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
        if (s > SMAX) s = SMAX;
        if (s < SMIN) s = SMIN;
        return s[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] gen_val();
        case ($urandom_range(0, 4))
            0: return '0;
            1: return DW'($urandom_range(0, 100));
            2: return DW'(-$urandom_range(1, 100));
            3: return $urandom_range(0, 1) ? 32'h7FFF_FF00 + DW'($urandom_range(0, 255))
                                           : 32'h8000_0000 + DW'($urandom_range(0, 255));
            default: return $urandom();
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        clear = 1'b0; acc_mode = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b0; in_data = '0;
    endtask

    // Sends DEPTH rows from pd; first marks the tile's first pass.
    task automatic run_pass(input bit first, input bit accm, input bit last);
        for (int r = 0; r < DEPTH; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (first || !accm) begin
                    m_wrap[r][c] = pd[r][c];
                    m_sat[r][c]  = pd[r][c];
                end else begin
                    m_wrap[r][c] = m_wrap[r][c] + pd[r][c];
                    m_sat[r][c]  = sat_add(m_sat[r][c], pd[r][c]);
                end
                in_data[c*DW +: DW] = pd[r][c];
            end
            acc_mode = accm;
            in_last  = last;
            in_valid = 1'b1;
            check("in_ready", RW'(in_ready_w), RW'(1));
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
        check("draining_after_pass", RW'(draining_w), RW'(last));
        check("out_valid_after_pass", RW'(out_valid_s), RW'(last));
    endtask

    task automatic run_tile(input int passes, input bit accm);
        for (int p = 0; p < passes; p++) begin
            if (p > 0) begin
                for (int r = 0; r < DEPTH; r++)
                    for (int c = 0; c < COLS; c++)
                        pd[r][c] = gen_val();
            end
            run_pass(p == 0, accm, p == passes - 1);
        end
    endtask

    // mode 0: ready high, 1: pattern 1,0,0 repeating, 2: random.
    // Stops after max_hs handshakes (DEPTH for a full drain).
    task automatic drain(input int mode, input int max_hs);
        int hs;
        int cyc;
        logic [RW-1:0] rw;
        logic [RW-1:0] rs;
        hs = 0;
        cyc = 0;
        exp_q_w.delete();
        exp_q_s.delete();
        for (int r = 0; r < DEPTH; r++) begin
            for (int c = 0; c < COLS; c++) begin
                rw[c*DW +: DW] = m_wrap[r][c];
                rs[c*DW +: DW] = m_sat[r][c];
            end
            exp_q_w.push_back(rw);
            exp_q_s.push_back(rs);
        end
        while (hs < max_hs && cyc < 200) begin
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = (cyc % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            check("out_valid", RW'(out_valid_w), RW'(1));
            check("in_ready_drain", RW'(in_ready_w), RW'(0));
            check("out_data_wrap", out_data_w, exp_q_w[0]);
            check("out_data_sat", out_data_s, exp_q_s[0]);
            check("out_last", RW'(out_last_w), RW'(hs == DEPTH - 1));
            if (out_ready) begin
                hs++;
                void'(exp_q_w.pop_front());
                void'(exp_q_s.pop_front());
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        out_ready = 1'b0;
        if (hs < max_hs) check("drain_timeout", RW'(hs), RW'(max_hs));
        if (max_hs == DEPTH) begin
            check("post_drain_valid", RW'(out_valid_w), RW'(0));
            check("post_drain_state", RW'({draining_w, draining_s}), RW'(0));
            check("post_drain_ready", RW'(in_ready_w), RW'(1));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, RW'({in_ready_w, in_ready_s}), RW'(2'b11));
        check({tag, "_out_valid"}, RW'({out_valid_w, out_valid_s}), RW'(0));
        check({tag, "_out_last"}, RW'({out_last_w, out_last_s}), RW'(0));
        check({tag, "_draining"}, RW'({draining_w, draining_s}), RW'(0));
        check({tag, "_out_data"}, out_data_w | out_data_s, RW'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        idle_inputs();
        reset = 1'b1;
        #1;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // single pass, accumulate mode
        for (int r = 0; r < DEPTH; r++) begin
            pd[r][0] = DW'(r + 1);
            pd[r][1] = DW'(10 * (r + 1));
        end
        run_pass(1'b1, 1'b1, 1'b1);
        drain(0, DEPTH);

        // three passes of {5,0}: zero lanes are still ordinary rows
        for (int r = 0; r < DEPTH; r++) begin
            pd[r][0] = 32'd5;
            pd[r][1] = 32'd0;
        end
        run_pass(1'b1, 1'b1, 1'b0);
        run_pass(1'b0, 1'b1, 1'b0);
        run_pass(1'b0, 1'b1, 1'b1);
        drain(0, DEPTH);

        // overwrite mode: {7,7} then {2,3}
        for (int r = 0; r < DEPTH; r++) begin pd[r][0] = 32'd7; pd[r][1] = 32'd7; end
        run_pass(1'b1, 1'b0, 1'b0);
        for (int r = 0; r < DEPTH; r++) begin pd[r][0] = 32'd2; pd[r][1] = 32'd3; end
        run_pass(1'b0, 1'b0, 1'b1);
        drain(0, DEPTH);

        // overflow in both directions, wrapping vs saturating instance
        for (int r = 0; r < DEPTH; r++) begin pd[r][0] = 32'h7FFF_FFF0; pd[r][1] = 32'h8000_0001; end
        run_pass(1'b1, 1'b1, 1'b0);
        for (int r = 0; r < DEPTH; r++) begin pd[r][0] = 32'h0000_0020; pd[r][1] = 32'hFFFF_FFFB; end
        run_pass(1'b0, 1'b1, 1'b1);
        drain(0, DEPTH);

        // backpressure, then a fresh tile must overwrite the stale contents
        for (int r = 0; r < DEPTH; r++) begin pd[r][0] = DW'(100 + r); pd[r][1] = DW'(200 + r); end
        run_pass(1'b1, 1'b1, 1'b0);
        run_pass(1'b0, 1'b1, 1'b1);
        drain(1, DEPTH);
        for (int r = 0; r < DEPTH; r++) begin pd[r][0] = DW'(r); pd[r][1] = DW'(3 * r + 1); end
        run_pass(1'b1, 1'b1, 1'b1);
        drain(2, DEPTH);

        // clear after two rows of pass 2, with a beat presented alongside it
        for (int r = 0; r < DEPTH; r++) begin pd[r][0] = 32'd9; pd[r][1] = 32'd11; end
        run_pass(1'b1, 1'b1, 1'b0);
        for (int r = 0; r < 2; r++) begin
            in_data = {32'd1, 32'd1};
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        clear = 1'b1;
        in_data = {32'd77, 32'd77};
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        in_valid = 1'b0;
        check("clear_state", RW'({draining_w, in_ready_w}), RW'(2'b01));
        for (int r = 0; r < DEPTH; r++) begin pd[r][0] = DW'(40 + r); pd[r][1] = DW'(50 + r); end
        run_pass(1'b1, 1'b1, 1'b0);
        for (int r = 0; r < DEPTH; r++) begin pd[r][0] = 32'd1; pd[r][1] = 32'hFFFF_FFFF; end
        run_pass(1'b0, 1'b1, 1'b1);
        drain(0, DEPTH);

        // reset asserted mid-drain, then a correct tile afterwards
        for (int r = 0; r < DEPTH; r++) begin pd[r][0] = DW'(60 + r); pd[r][1] = DW'(70 + r); end
        run_pass(1'b1, 1'b1, 1'b0);
        run_pass(1'b0, 1'b1, 1'b1);
        drain(0, 2);
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_drain_reset");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int r = 0; r < DEPTH; r++) begin pd[r][0] = DW'(5 * r); pd[r][1] = DW'(7 * r + 2); end
        run_pass(1'b1, 1'b1, 1'b0);
        run_pass(1'b0, 1'b1, 1'b1);
        drain(0, DEPTH);

        // randomized tiles
        for (int t = 0; t < 12; t++) begin
            for (int r = 0; r < DEPTH; r++)
                for (int c = 0; c < COLS; c++)
                    pd[r][c] = gen_val();
            run_tile($urandom_range(1, 3), 1'($urandom_range(0, 3) != 0));
            drain($urandom_range(0, 2), DEPTH);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
